led_pattern_scheduler: RTL and testbench

Sequencer for the 8-LED display board. Generates its own step tick from the board clock at one of two rates and drives the two 2-LED patterns (running pair, fill/empty). It either follows a manual pattern switch or auto-alternates patterns after a programmable number of complete passes. It replaces the switch-selected divider and pattern multiplexing at the top level with a single scheduled controller.

---
 rtl/led_sched_pkg.sv | 23 ++
 rtl/led_pattern_scheduler_tick_prescaler.sv | 37 +++
 rtl/led_pattern_scheduler.sv | 100 ++++++++++
 tb/tb_led_pattern_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
// Shared constants and LED decode for the LED pattern scheduler.
package led_sched_pkg;

    localparam logic PAT_CHASE = 1'b1;
    localparam logic PAT_FILL  = 1'b0;

    localparam int PRESCALE_W = 27;
    typedef logic [PRESCALE_W-1:0] presc_t;

    localparam logic [7:0] CHASE_SEED = 8'h03;

    // Index 0 is the rightmost entry.
    localparam logic [7:0][7:0] FILL_TABLE = {
        8'hC0, 8'hF0, 8'hFC, 8'hFF, 8'h3F, 8'h0F, 8'h03, 8'h00
    };

    function automatic logic [7:0] led_decode(input logic pat, input logic [2:0] step);
        logic [15:0] rot;
        rot = {CHASE_SEED, CHASE_SEED} << step;
        return (pat == PAT_CHASE) ? rot[15:8] : FILL_TABLE[step];
    endfunction

endpackage

// File: rtl/led_pattern_scheduler_tick_prescaler.sv
// Step-tick generator: two selectable periods, restart on rate change, hold on pause.
module tick_prescaler
    import led_sched_pkg::*;
#(
    parameter int TICK_FAST = 50_000_000,
    parameter int TICK_SLOW = 100_000_000
) (
    input  logic clki,
    input  logic rs,
    input  logic rate_fast,
    input  logic pause,
    output logic tick
);

    presc_t count;
    presc_t last;
    logic   rate_prev;
    logic   rate_change;

    assign last        = rate_fast ? presc_t'(TICK_FAST - 1) : presc_t'(TICK_SLOW - 1);
    assign rate_change = (rate_fast != rate_prev);
    assign tick        = !rate_change && !pause && (count == last);

    // rate_prev tracks through reset so a rate held across reset is not seen as a change.
    always_ff @(posedge clki) begin
        rate_prev <= rate_fast;
        if (!rs) begin
            count <= '0;
        end else if (rate_change) begin
            count <= '0;
        end else if (!pause) begin
            if (count == last) count <= '0;
            else               count <= count + presc_t'(1);
        end
    end

endmodule

// File: rtl/led_pattern_scheduler.sv
// LED pattern scheduler: synchronizes switches, steps chase/fill patterns on each tick,
// and optionally alternates patterns after REPEAT complete passes.
//   pat_id | meaning
//   0      | fill/empty pattern
//   1      | running-pair chase pattern
module led_pattern_scheduler
    import led_sched_pkg::*;
#(
    parameter int TICK_FAST = 50_000_000,
    parameter int TICK_SLOW = 100_000_000,
    parameter int REPEAT    = 2
) (
    input  logic       clki,
    input  logic       rs,
    input  logic       S0,
    input  logic       S1,
    input  logic       auto_en,
    input  logic       pause,
    output logic [7:0] led,
    output logic       pat_id,
    output logic       pass_done
);

    localparam logic [3:0] REPEAT_LAST = 4'(REPEAT - 1);

    logic [1:0] s0_sync;
    logic [1:0] s1_sync;
    logic [1:0] auto_sync;
    logic [1:0] pause_sync;

    // Synchronizers are left unreset so held switch levels settle during reset.
    always_ff @(posedge clki) begin
        s0_sync    <= {s0_sync[0], S0};
        s1_sync    <= {s1_sync[0], S1};
        auto_sync  <= {auto_sync[0], auto_en};
        pause_sync <= {pause_sync[0], pause};
    end

    logic tick;

    tick_prescaler #(
        .TICK_FAST (TICK_FAST),
        .TICK_SLOW (TICK_SLOW)
    ) u_prescaler (
        .clki      (clki),
        .rs        (rs),
        .rate_fast (s1_sync[1]),
        .pause     (pause_sync[1]),
        .tick      (tick)
    );

    logic [2:0] step;
    logic [3:0] pass_cnt;
    logic [2:0] step_nxt;
    logic [3:0] pass_nxt;
    logic       pat_nxt;
    logic       done_nxt;

    always_comb begin
        step_nxt = step;
        pass_nxt = pass_cnt;
        pat_nxt  = pat_id;
        done_nxt = 1'b0;
        if (tick) begin
            if (!auto_sync[1] && (s0_sync[1] != pat_id)) begin
                pat_nxt  = s0_sync[1];
                step_nxt = 3'd0;
                pass_nxt = 4'd0;
            end else if (step == 3'd7) begin
                step_nxt = 3'd0;
                done_nxt = 1'b1;
                if (auto_sync[1] && (pass_cnt == REPEAT_LAST)) begin
                    pat_nxt  = ~pat_id;
                    pass_nxt = 4'd0;
                end else begin
                    pass_nxt = pass_cnt + 4'd1;
                end
            end else begin
                step_nxt = step + 3'd1;
            end
        end
    end

    always_ff @(posedge clki) begin
        if (!rs) begin
            step      <= 3'd0;
            pass_cnt  <= 4'd0;
            pat_id    <= PAT_FILL;
            led       <= 8'h00;
            pass_done <= 1'b0;
        end else begin
            step      <= step_nxt;
            pass_cnt  <= pass_nxt;
            pat_id    <= pat_nxt;
            pass_done <= done_nxt;
            if (tick) led <= led_decode(pat_nxt, step_nxt);
        end
    end

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Bench for led_pattern_scheduler: directed scenarios plus random switching,
// every cycle compared against a pass/position-based reference model.
module tb_led_pattern_scheduler;

    localparam int REPEAT = 2;

    logic       clki = 1'b0;
    logic       rs;
    logic       S0;
    logic       S1;
    logic       auto_en;
    logic       pause;
    logic [7:0] led;
    logic       pat_id;
    logic       pass_done;

    led_pattern_scheduler #(
        .TICK_FAST (4),
        .TICK_SLOW (8),
        .REPEAT    (REPEAT)
    ) dut (
        .clki      (clki),
        .rs        (rs),
        .S0        (S0),
        .S1        (S1),
        .auto_en   (auto_en),
        .pause     (pause),
        .led       (led),
        .pat_id    (pat_id),
        .pass_done (pass_done)
    );

    always #5 clki = ~clki;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] fill_exp [8] = '{8'h03, 8'h0F, 8'h3F, 8'hFF, 8'hFC, 8'hF0, 8'hC0, 8'h00};

    // Reference model: pattern progress kept as ticks since the pattern started.
    bit [1:0]   m_s0, m_s1, m_au, m_ps;
    bit         m_s1_prev;
    int         m_cnt;
    int         m_pos;
    bit         m_pat;
    logic [7:0] m_led;
    bit         m_pd;

    function automatic logic [7:0] pattern(input bit chase, input int s);
        int x;
        if (chase) begin
            x = 3 << s;
            return 8'((x | (x >> 8)) & 255);
        end
        if (s == 0) return 8'h00;
        if (s <= 4) return 8'((1 << (2 * s)) - 1);
        return 8'((255 << (2 * (s - 4))) & 255);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int div;
        bit tick;
        div  = m_s1[1] ? 4 : 8;
        tick = 0;
        if (!rs) begin
            m_cnt = 0; m_pos = 0; m_pat = 0; m_led = 8'h00; m_pd = 0;
        end else begin
            if (m_s1[1] != m_s1_prev) m_cnt = 0;
            else if (!m_ps[1]) begin
                if (m_cnt == div - 1) begin tick = 1; m_cnt = 0; end
                else m_cnt++;
            end
            m_pd = 0;
            if (tick) begin
                if (!m_au[1] && (m_s0[1] != m_pat)) begin
                    m_pat = m_s0[1];
                    m_pos = 0;
                end else begin
                    m_pos++;
                    if (m_pos % 8 == 0) begin
                        m_pd = 1;
                        if (m_au[1] && (((m_pos / 8) - 1) % 16) == REPEAT - 1) begin
                            m_pat = !m_pat;
                            m_pos = 0;
                        end
                    end
                end
                m_led = pattern(m_pat, m_pos % 8);
            end
        end
        m_s1_prev = m_s1[1];
        m_s0 = {m_s0[0], S0};
        m_s1 = {m_s1[0], S1};
        m_au = {m_au[0], auto_en};
        m_ps = {m_ps[0], pause};
    endtask

    task automatic cycle();
        @(posedge clki);
        model_edge();
        #1;
        check("model_led", 32'(led), 32'(m_led));
        check("model_pat", 32'(pat_id), 32'(m_pat));
        check("model_pass_done", 32'(pass_done), 32'(m_pd));
    endtask

    initial begin
        int         pulses;
        int         n;
        bit         stable;
        logic [7:0] held_led;
        logic       held_pat;

        rs = 0; S0 = 0; S1 = 1; auto_en = 0; pause = 0;

        // Scenario 1: manual fill at fast rate
        repeat (4) cycle();
        check("rst_led", 32'(led), 'h00);
        check("rst_pat", 32'(pat_id), 0);
        check("rst_pass_done", 32'(pass_done), 0);
        rs = 1;
        pulses = 0;
        for (int t = 0; t < 8; t++) begin
            for (int c = 0; c < 4; c++) begin
                cycle();
                if (pass_done) pulses++;
            end
            check("s1_led_seq", 32'(led), 32'(fill_exp[t]));
        end
        check("s1_pass_done_on_wrap", 32'(pass_done), 1);
        check("s1_pulse_count", 32'(pulses), 1);

        // Scenario 2: auto alternation
        rs = 0; auto_en = 1;
        repeat (4) cycle();
        rs = 1;
        repeat (64) cycle();
        check("s2_pat_after_2_fill", 32'(pat_id), 1);
        check("s2_led_chase_start", 32'(led), 'h03);
        repeat (60) cycle();
        check("s2_led_chase_end", 32'(led), 'h81);
        check("s2_pat_chase_end", 32'(pat_id), 1);
        repeat (4) cycle();
        check("s2_pat_back_fill", 32'(pat_id), 0);
        check("s2_led_back_fill", 32'(led), 'h00);
        check("s2_pass_done_switch", 32'(pass_done), 1);

        // Scenario 3: manual switch mid-pass
        rs = 0; auto_en = 0; S0 = 0;
        repeat (4) cycle();
        rs = 1;
        repeat (12) cycle();
        check("s3_fill_step3", 32'(led), 'h3F);
        cycle();
        S0 = 1;
        repeat (3) cycle();
        check("s3_led_switch", 32'(led), 'h03);
        check("s3_pat_switch", 32'(pat_id), 1);
        check("s3_no_pass_done", 32'(pass_done), 0);

        // Scenario 4: rate change mid-count restarts the prescaler at the slow period
        cycle();
        S1 = 0;
        held_led = led;
        n = 0;
        while (n < 40) begin
            cycle();
            n++;
            if (led !== held_led) break;
        end
        check("s4_cycles_to_tick", 32'(n), 11);

        // Scenario 5: pause across a would-be tick
        repeat (5) cycle();
        pause = 1;
        held_led = led;
        held_pat = pat_id;
        stable = 1;
        repeat (20) begin
            cycle();
            if (led !== held_led || pat_id !== held_pat || pass_done !== 1'b0) stable = 0;
        end
        check("s5_outputs_frozen", 32'(stable), 1);
        pause = 0;
        n = 0;
        while (n < 40) begin
            cycle();
            n++;
            if (led !== held_led) break;
        end
        check("s5_cycles_after_release", 32'(n), 3);

        // Scenario 6: reset mid chase pass
        rs = 0; S1 = 1; auto_en = 1;
        repeat (4) cycle();
        rs = 1;
        repeat (116) cycle();
        check("s6_chase_step5", 32'(led), 'h60);
        check("s6_pat_chase", 32'(pat_id), 1);
        rs = 0;
        cycle();
        check("s6_rst_led", 32'(led), 'h00);
        check("s6_rst_pat", 32'(pat_id), 0);
        check("s6_rst_pass_done", 32'(pass_done), 0);
        rs = 1;
        repeat (4) cycle();
        check("s6_restart_led", 32'(led), 'h03);
        repeat (28) cycle();
        check("s6_restart_wrap_led", 32'(led), 'h00);
        check("s6_restart_pass_done", 32'(pass_done), 1);

        // Random switching, occasional reset pulses
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) S0 = ~S0;
            if ($urandom_range(0, 59) == 0) S1 = ~S1;
            if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 29) == 0) pause = ~pause;
            rs = ($urandom_range(0, 499) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
